// File: rtl/psum_drain.sv
// psum_drain: realigns skewed bottom-row psums into rows and buffers them in a FIFO.
// Optional build macro PSUM_RELU_EN clamps negative column values to zero at the FIFO write port.
module psum_drain #(
  parameter int NUM_COLS   = 4,
  parameter int PSUM_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           row_start,
  input  logic [NUM_COLS*PSUM_WIDTH-1:0] psum_in,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_COLS*PSUM_WIDTH-1:0] out_data,
  output logic [$clog2(FIFO_DEPTH):0]    row_count,
  output logic                           overflow
);

  localparam int W  = PSUM_WIDTH;
  localparam int DW = NUM_COLS * PSUM_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SL = NUM_COLS - 1;

  logic [SL-1:0] vld_sr;
  logic [DW-1:0] aligned;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [31:0]   occ;

  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= (vld_sr << 1) | SL'(row_start);
  end

  // Column c waits NUM_COLS-1-c cycles so all columns land together.
  for (genvar c = 0; c < SL; c++) begin : g_dly
    localparam int D = SL - c;
    logic [W-1:0] sr [D];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < D; k++) sr[k] <= '0;
      end else begin
        sr[0] <= psum_in[c*W +: W];
        for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
      end
    end

    assign aligned[c*W +: W] = sr[D-1];
  end

  assign aligned[SL*W +: W] = psum_in[SL*W +: W];

  always_comb begin
    wdata = aligned;
`ifdef PSUM_RELU_EN
    for (int c = 0; c < NUM_COLS; c++) begin
      if (aligned[c*W+W-1]) wdata[c*W +: W] = '0;
    end
`endif
  end

  always_comb begin
    occ = 32'(cnt);
    for (int i = 0; i < SL; i++) occ = occ + 32'(vld_sr[i]);
  end

  assign in_ready = occ < 32'(FIFO_DEPTH);
  assign push     = vld_sr[SL-1];
  assign full     = cnt == CW'(FIFO_DEPTH);
  assign pop      = out_valid && out_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr_en)         wptr <= wptr + 1'b1;
      if (pop)           rptr <= rptr + 1'b1;
      if (push && !wr_en) ovf <= 1'b1;
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  assign out_valid = cnt != '0;
  assign out_data  = out_valid ? mem[rptr] : '0;
  assign row_count = cnt;
  assign overflow  = ovf;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed plus random checks of psum_drain against a row-level queue model.
// Expectations follow the PSUM_RELU_EN macro when it is defined for the build.
module tb_psum_drain;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int DW = N * W;

  typedef struct packed {
    logic [DW-1:0] d;
    int            age;
  } fl_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          row_start = 0;
  logic [DW-1:0] psum_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 0;
  logic [DW-1:0] out_data;
  logic [2:0]    row_count;
  logic          overflow;

  psum_drain #(.NUM_COLS(N), .PSUM_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .row_start(row_start), .psum_in(psum_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .row_count(row_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  fl_t           inflight[$];
  logic [DW-1:0] mq[$];
  logic          m_ovf = 0;
  int            nvec = 0;
  int            nerr = 0;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] r);
    logic [DW-1:0] v;
    v = r;
`ifdef PSUM_RELU_EN
    for (int c = 0; c < N; c++)
      if (r[c*W+W-1]) v[c*W +: W] = '0;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [DW-1:0] hd;
    hd = (mq.size() != 0) ? mq[0] : '0;
    check("m_out_valid", DW'(out_valid), DW'(mq.size() != 0));
    check("m_out_data", out_data, hd);
    check("m_row_count", DW'(row_count), DW'(mq.size()));
    check("m_overflow", DW'(overflow), DW'(m_ovf));
    check("m_in_ready", DW'(in_ready),
          DW'((mq.size() + inflight.size()) < D));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare at negedge.
  task automatic cycle(input logic rs, input logic [DW-1:0] row,
                       input logic ordy, input logic r);
    logic [DW-1:0] bus;
    logic [DW-1:0] pd;
    bit            pop;
    bit            psh;
    int            sz;
    if (rs && !r) inflight.push_back('{d: row, age: 0});
    bus = {$urandom, $urandom};
    foreach (inflight[i])
      bus[inflight[i].age*W +: W] = inflight[i].d[inflight[i].age*W +: W];
    rst = r;
    row_start = rs;
    out_ready = ordy;
    psum_in = bus;
    @(posedge clk);
    if (r) begin
      inflight.delete();
      mq.delete();
      m_ovf = 0;
    end else begin
      sz = mq.size();
      pop = (sz > 0) && ordy;
      psh = 0;
      pd = '0;
      if (inflight.size() > 0 && inflight[0].age == N - 1) begin
        psh = 1;
        pd = relu(inflight[0].d);
        void'(inflight.pop_front());
      end
      if (pop) void'(mq.pop_front());
      if (psh) begin
        if (sz < D || pop) mq.push_back(pd);
        else m_ovf = 1;
      end
      foreach (inflight[i]) inflight[i].age++;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(0, '0, ordy, 0);
  endtask

  logic [DW-1:0] rows [5];
  logic [DW-1:0] relu_exp;

  initial begin
    rows[0] = 64'h1001_1002_1003_1004;
    rows[1] = 64'h2001_2002_2003_2004;
    rows[2] = 64'h3001_3002_3003_3004;
    rows[3] = 64'h4001_4002_4003_4004;
    rows[4] = 64'h5001_5002_5003_5004;
    @(negedge clk);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    idle(1, 0);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_row_count", DW'(row_count), '0);
    check("rst_overflow", DW'(overflow), '0);
    check("rst_in_ready", DW'(in_ready), DW'(1));

    // Single row: valid appears NUM_COLS cycles after row_start.
    cycle(1, 64'h0044_0033_0022_0011, 0, 0);
    idle(2, 0);
    check("lat_early", DW'(out_valid), '0);
    idle(1, 0);
    check("lat_valid", DW'(out_valid), DW'(1));
    check("single_data", out_data, 64'h0044_0033_0022_0011);
    check("single_cnt", DW'(row_count), DW'(1));
    idle(1, 1);
    check("single_pop", DW'(row_count), '0);

    // Back-to-back with stall.
    for (int i = 0; i < 4; i++) cycle(1, rows[i], 0, 0);
    check("b2b_in_ready", DW'(in_ready), '0);
    idle(3, 0);
    check("b2b_cnt", DW'(row_count), DW'(4));
    check("b2b_ovf", DW'(overflow), '0);
    for (int i = 0; i < 4; i++) begin
      check("b2b_order", out_data, rows[i]);
      cycle(0, '0, 1, 0);
    end
    check("b2b_empty", DW'(out_valid), '0);

    // Overflow: fifth row dropped while stalled.
    for (int i = 0; i < 5; i++) cycle(1, rows[i], 0, 0);
    idle(3, 0);
    check("ovf_cnt", DW'(row_count), DW'(4));
    check("ovf_flag", DW'(overflow), DW'(1));
    check("ovf_head", out_data, rows[0]);
    idle(2, 0);
    check("ovf_sticky", DW'(overflow), DW'(1));
    cycle(0, '0, 0, 1);

    // Full FIFO with push and pop together.
    for (int i = 0; i < 5; i++) cycle(1, rows[i], 0, 0);
    idle(2, 0);
    check("fpp_full", DW'(row_count), DW'(4));
    cycle(0, '0, 1, 0);
    check("fpp_cnt", DW'(row_count), DW'(4));
    check("fpp_ovf", DW'(overflow), '0);
    check("fpp_head", out_data, rows[1]);
    cycle(0, '0, 0, 1);

    // Reset while a row is in flight.
    cycle(1, rows[2], 0, 0);
    idle(1, 0);
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1);
      check("mrst_valid", DW'(out_valid), '0);
      check("mrst_data", out_data, '0);
      check("mrst_cnt", DW'(row_count), '0);
    end
    check("mrst_ready", DW'(in_ready), DW'(1));

    // Negative column value.
`ifdef PSUM_RELU_EN
    relu_exp = 64'h0004_0003_0000_0001;
`else
    relu_exp = 64'h0004_0003_FFF0_0001;
`endif
    cycle(1, 64'h0004_0003_FFF0_0001, 0, 0);
    idle(3, 0);
    check("relu_data", out_data, relu_exp);
    idle(1, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      cycle(!r && $urandom_range(0, 1), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
